ibis_video_timing_gen: RTL
==========================

Name: ibis_video_timing_gen

Overview:
- Parametrised, run-time reprogrammable raster timing generator. Successor to the fixed 640x480@60 VGA timing block.
- Divides the TMDS-rate aclk down to a pixel strobe and counts X/Y across active, front porch, sync and back porch.
- Drives sync, blanking, data-enable, line/frame strobes and pixel ordinates to the TMDS encoder and the pixel fetch path.
- Accepts new mode timings via a valid/ready handshake and applies them only at a frame boundary (tear-free mode switch).

Parameters:
- CLK_DIV, 5, aclk cycles per pixel (>=1; 1 means pix_stb every enabled cycle)
- XW, 12, width of X counter and horizontal config fields
- YW, 11, width of Y counter and vertical config fields
- H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48, reset horizontal timings in pixels
- V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, reset vertical timings in lines
- HSYNC_POL/VSYNC_POL, 0/0, reset sync polarity (0 = active-low)

Ports:
- aclk  in  1  clock (TMDS-rate)
- areset  in  1  synchronous reset, active-high
- enable  in  1  advance divider and counters; low freezes all state
- cfg_valid  in  1  new timing set offered
- cfg_ready  out  1  shadow register free
- cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp  in  XW each  horizontal timings
- cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp  in  YW each  vertical timings
- cfg_hsync_pol, cfg_vsync_pol  in  1 each  sync polarity
- cfg_err  out  1  one-cycle pulse: offered config rejected
- pix_stb  out  1  pixel-rate strobe
- ord_x  out  XW  current pixel X, 0-based
- ord_y  out  YW  current line Y, 0-based
- hsync, vsync  out  1 each  sync at programmed polarity
- hblankn, vblankn  out  1 each  high during active region
- de  out  1  hblankn & vblankn
- line_start  out  1  one-pixel-period-aligned pulse, one aclk wide
- frame_start  out  1  pulse, one aclk wide

Behaviour:
- Reset (areset high at aclk edge): divider=0; ord_x=ord_y=0; live and shadow timings = parameter defaults; shadow pending=0; cfg_ready=1; pix_stb=line_start=frame_start=cfg_err=0; hblankn=vblankn=de=1; hsync=!HSYNC_POL; vsync=!VSYNC_POL. Reset mid-frame aborts the frame and discards any pending shadow.
- Divider: counts 0..CLK_DIV-1 while enable is high, wrapping to 0. pix_stb is registered and high for exactly the one aclk where the divider wraps. enable low holds the divider, counters and all outputs; pulses drop to 0.
- Derived totals: HT = h_active+h_fp+h_sync+h_bp and VT similarly, computed at XW+2/YW+2 bits from the live set.
- Counting: on pix_stb, ord_x increments. At ord_x==HT-1, ord_x wraps to 0 and ord_y increments. At ord_y==VT-1 with an X wrap, ord_y wraps to 0.
- Output timing: all outputs are registered and update in the same aclk as the ord_x/ord_y they describe.
  - hblankn = x<h_active
  - hsync asserted for h_active+h_fp <= x < h_active+h_fp+h_sync
  - vertical signals follow the same rule in y
  - line_start=1 when the update lands on x==0
  - frame_start=1 when the update lands on (0,0)
- Config handshake:
  - Transfer when cfg_valid & cfg_ready. Fields are captured into the shadow set; pending=1; cfg_ready=0.
  - Validation: any field ==0, or HT/VT exceeding 2^XW / 2^YW, is rejected. On rejection: shadow unchanged, pending unchanged, cfg_err pulses the next cycle, cfg_ready stays 1.
  - Apply: on the pix_stb that wraps both counters to (0,0) with pending=1, the live set takes the shadow, pending clears, and cfg_ready returns to 1 the following aclk. Outputs for (0,0) use the new set, including polarity.
  - A transfer in the same aclk as the frame wrap is not applied at that wrap; it waits for the next one.
- Counter overrun safeguard: if a counter is ever >= its total (not expected after the apply rule), it wraps to 0 on the next pix_stb.

Test Plan:
- Reset, enable=1, defaults, CLK_DIV=5 -> pix_stb every 5th aclk.
  - ord_x sequence 0..799 and ord_y 0..524.
  - hsync low for x 656..751; vsync low for y 490..491.
  - de high for x<640 & y<480.
  - frame_start once per 800*525*5 aclks.
- Program 1280x720 timings (1280/110/40/220, 720/5/5/20, pol 1/1) mid-frame.
  - cfg_ready drops; old timings persist to the end of the frame.
  - At the next (0,0): HT=1650, VT=750, hsync high for x 1390..1429.
- Offer cfg_h_sync=0 -> cfg_err pulses one cycle; live timings unchanged; cfg_ready stays 1.
- cfg_valid coincident with the frame-wrap pix_stb -> not applied at that wrap; applied exactly one frame later.
- enable low for 37 aclks mid-line -> ord_x, ord_y, divider and outputs frozen; resume with no skipped or duplicated pixel.
- areset mid-frame with pending shadow -> all outputs at reset values the next cycle; shadow discarded; defaults resume from (0,0).

Source files
------------

// File: rtl/ibis_video_timing_gen.sv
// rtl/ibis_video_timing_gen.sv - reprogrammable raster timing generator with frame-boundary mode switch
module ibis_video_timing_gen #(
  parameter int CLK_DIV   = 5,
  parameter int XW        = 12,
  parameter int YW        = 11,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          enable,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [XW-1:0] cfg_h_active,
  input  logic [XW-1:0] cfg_h_fp,
  input  logic [XW-1:0] cfg_h_sync,
  input  logic [XW-1:0] cfg_h_bp,
  input  logic [YW-1:0] cfg_v_active,
  input  logic [YW-1:0] cfg_v_fp,
  input  logic [YW-1:0] cfg_v_sync,
  input  logic [YW-1:0] cfg_v_bp,
  input  logic          cfg_hsync_pol,
  input  logic          cfg_vsync_pol,
  output logic          cfg_err,
  output logic          pix_stb,
  output logic [XW-1:0] ord_x,
  output logic [YW-1:0] ord_y,
  output logic          hsync,
  output logic          vsync,
  output logic          hblankn,
  output logic          vblankn,
  output logic          de,
  output logic          line_start,
  output logic          frame_start
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HW = XW + 2;
  localparam int VW = YW + 2;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LIMIT  = {2'b01, {XW{1'b0}}};
  localparam logic [VW-1:0] V_LIMIT  = {2'b01, {YW{1'b0}}};

  typedef struct packed {
    logic [XW-1:0] ha, hfp, hs, hbp;
    logic [YW-1:0] va, vfp, vs, vbp;
    logic          hpol, vpol;
  } timing_t;

  localparam timing_t DEFAULTS = '{ha: XW'(H_ACTIVE), hfp: XW'(H_FP), hs: XW'(H_SYNC), hbp: XW'(H_BP),
                                   va: YW'(V_ACTIVE), vfp: YW'(V_FP), vs: YW'(V_SYNC), vbp: YW'(V_BP),
                                   hpol: HSYNC_POL, vpol: VSYNC_POL};

  function automatic logic [HW-1:0] h_total(input timing_t t);
    return HW'(t.ha) + HW'(t.hfp) + HW'(t.hs) + HW'(t.hbp);
  endfunction

  function automatic logic [VW-1:0] v_total(input timing_t t);
    return VW'(t.va) + VW'(t.vfp) + VW'(t.vs) + VW'(t.vbp);
  endfunction

  logic [DW-1:0] div_q, div_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  timing_t       live_q, live_d, shadow_q, shadow_d, cfg_in;
  logic          pending_q, pending_d, err_q, err_d, stb_q, stb_d;
  logic          ls_q, ls_d, fs_q, fs_d, hs_q, hs_d, vs_q, vs_d;
  logic          hb_q, hb_d, vb_q, vb_d, de_q, de_d;
  logic [HW-1:0] ht, h_so, h_eo;
  logic [VW-1:0] vt, v_so, v_eo;
  logic          x_last, y_last, cfg_ok;

  always_comb begin
    div_d     = div_q;
    x_d       = x_q;
    y_d       = y_q;
    live_d    = live_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    err_d     = 1'b0;
    stb_d     = 1'b0;
    ls_d      = 1'b0;
    fs_d      = 1'b0;
    hs_d      = hs_q;
    vs_d      = vs_q;
    hb_d      = hb_q;
    vb_d      = vb_q;
    de_d      = de_q;
    h_so      = '0;
    h_eo      = '0;
    v_so      = '0;
    v_eo      = '0;

    cfg_in = '{ha: cfg_h_active, hfp: cfg_h_fp, hs: cfg_h_sync, hbp: cfg_h_bp,
               va: cfg_v_active, vfp: cfg_v_fp, vs: cfg_v_sync, vbp: cfg_v_bp,
               hpol: cfg_hsync_pol, vpol: cfg_vsync_pol};

    ht     = h_total(live_q);
    vt     = v_total(live_q);
    // ">=" rather than "==" also recovers a counter that somehow sits beyond its total
    x_last = {2'b00, x_q} >= (ht - HW'(1));
    y_last = {2'b00, y_q} >= (vt - VW'(1));

    if (enable) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
      if (div_q == DIV_LAST) begin
        stb_d = 1'b1;
        if (x_last) begin
          x_d = '0;
          y_d = y_last ? '0 : y_q + YW'(1);
          if (y_last && pending_q) begin
            live_d    = shadow_q;
            pending_d = 1'b0;
          end
        end else begin
          x_d = x_q + XW'(1);
          if ({2'b00, y_q} >= vt) y_d = '0;
        end

        // Outputs describe the new position using the set that is live there
        h_so = HW'(live_d.ha) + HW'(live_d.hfp);
        h_eo = h_so + HW'(live_d.hs);
        v_so = VW'(live_d.va) + VW'(live_d.vfp);
        v_eo = v_so + VW'(live_d.vs);
        hb_d = {2'b00, x_d} < HW'(live_d.ha);
        vb_d = {2'b00, y_d} < VW'(live_d.va);
        hs_d = (({2'b00, x_d} >= h_so) && ({2'b00, x_d} < h_eo)) ? live_d.hpol : ~live_d.hpol;
        vs_d = (({2'b00, y_d} >= v_so) && ({2'b00, y_d} < v_eo)) ? live_d.vpol : ~live_d.vpol;
        de_d = hb_d & vb_d;
        ls_d = (x_d == '0);
        fs_d = (x_d == '0) && (y_d == '0);
      end
    end

    cfg_ok = (cfg_in.ha != '0) && (cfg_in.hfp != '0) && (cfg_in.hs != '0) && (cfg_in.hbp != '0) &&
             (cfg_in.va != '0) && (cfg_in.vfp != '0) && (cfg_in.vs != '0) && (cfg_in.vbp != '0) &&
             (h_total(cfg_in) <= H_LIMIT) && (v_total(cfg_in) <= V_LIMIT);

    // Apply needs pending=1 and transfer needs pending=0, so they never collide
    if (cfg_valid && !pending_q) begin
      if (cfg_ok) begin
        shadow_d  = cfg_in;
        pending_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      div_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      live_q    <= DEFAULTS;
      shadow_q  <= DEFAULTS;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      stb_q     <= 1'b0;
      ls_q      <= 1'b0;
      fs_q      <= 1'b0;
      hs_q      <= ~HSYNC_POL;
      vs_q      <= ~VSYNC_POL;
      hb_q      <= 1'b1;
      vb_q      <= 1'b1;
      de_q      <= 1'b1;
    end else begin
      div_q     <= div_d;
      x_q       <= x_d;
      y_q       <= y_d;
      live_q    <= live_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      stb_q     <= stb_d;
      ls_q      <= ls_d;
      fs_q      <= fs_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      hb_q      <= hb_d;
      vb_q      <= vb_d;
      de_q      <= de_d;
    end
  end

  assign cfg_ready   = ~pending_q;
  assign cfg_err     = err_q;
  assign pix_stb     = stb_q;
  assign ord_x       = x_q;
  assign ord_y       = y_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign hblankn     = hb_q;
  assign vblankn     = vb_q;
  assign de          = de_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule
